// File: rtl/uart_boot_loader_if.sv
// Byte-stream input and memory write port bundle for uart_boot_loader.
// With BOOT_LOADER_ACK_EN defined it also carries the status-byte transmit handshake.
interface uart_boot_loader_if #(
    parameter int ADDR_WIDTH  = 14,
    parameter int NUM_TARGETS = 2
);
    logic [7:0]             rx_data;
    logic                   rx_tick;
    logic [NUM_TARGETS-1:0] wen;
    logic [ADDR_WIDTH-1:0]  waddr;
    logic [31:0]            wdata;
`ifdef BOOT_LOADER_ACK_EN
    logic [7:0]             tx_data;
    logic                   tx_req;
    logic                   tx_ready;

    modport master (
        input  rx_data, rx_tick, tx_ready,
        output wen, waddr, wdata, tx_data, tx_req
    );
    modport slave (
        output rx_data, rx_tick, tx_ready,
        input  wen, waddr, wdata, tx_data, tx_req
    );
`else
    modport master (
        input  rx_data, rx_tick,
        output wen, waddr, wdata
    );
    modport slave (
        output rx_data, rx_tick,
        input  wen, waddr, wdata
    );
`endif
endinterface

// File: rtl/uart_boot_loader.sv
// Framed UART boot loader: parses A5/TGT/ADDR/LEN/DATA/CSUM packets into per-target word writes.
// Optional status byte reply (0x06/0x15/0x16/0x17) is enabled by defining BOOT_LOADER_ACK_EN.
module uart_boot_loader #(
    parameter int ADDR_WIDTH     = 14,
    parameter int NUM_TARGETS    = 2,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               prog_en_i,
    uart_boot_loader_if.master bus,
    output logic               rst_out_o,
    output logic               busy_o,
    output logic               err_o
);
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_TGT  = 3'd1;
    localparam logic [2:0] ST_ADDR = 3'd2;
    localparam logic [2:0] ST_LEN  = 3'd3;
    localparam logic [2:0] ST_DATA = 3'd4;
    localparam logic [2:0] ST_CSUM = 3'd5;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] NUM_TGT8  = 8'(NUM_TARGETS);

    localparam int         TW           = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [2:0]             state_q, state_d;
    logic [1:0]             cnt_q, cnt_d;
    logic [7:0]             tgt_q, tgt_d;
    logic [31:0]            shift_q, shift_d;
    logic [ADDR_WIDTH-1:0]  wptr_q, wptr_d;
    logic [15:0]            left_q, left_d;
    logic [7:0]             csum_q, csum_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [NUM_TARGETS-1:0] wen_q, wen_d;
    logic [ADDR_WIDTH-1:0]  waddr_q, waddr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic                   err_q, err_d;
    logic                   rst_out_q, rst_out_d;

    logic                   busy;
    logic                   tgt_ok;
    logic                   timed_out;
    logic [31:0]            next_word;
    logic [7:0]             next_csum;

    assign busy      = (state_q != ST_IDLE);
    assign tgt_ok    = (tgt_q < NUM_TGT8);
    assign timed_out = busy && !bus.rx_tick && (timer_q == TIMEOUT_LAST);
    assign next_word = {bus.rx_data, shift_q[31:8]};
    assign next_csum = csum_q ^ bus.rx_data;

    // Little-endian fields are shifted in from the top, so after N bytes they sit in the upper N bytes.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tgt_d     = tgt_q;
        shift_d   = shift_q;
        wptr_d    = wptr_q;
        left_d    = left_q;
        csum_d    = csum_q;
        wen_d     = '0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        rst_out_d = prog_en_i | busy | err_q;

        if (!busy || bus.rx_tick) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + TW'(1);
        end

        if (timed_out) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
        end else if (bus.rx_tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.rx_data == SYNC_BYTE && prog_en_i) begin
                        state_d = ST_TGT;
                        csum_d  = '0;
                        cnt_d   = '0;
                    end
                end
                ST_TGT: begin
                    tgt_d   = bus.rx_data;
                    csum_d  = next_csum;
                    cnt_d   = '0;
                    state_d = ST_ADDR;
                end
                ST_ADDR: begin
                    shift_d = next_word;
                    csum_d  = next_csum;
                    cnt_d   = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        wptr_d  = next_word[ADDR_WIDTH-1:0];
                        state_d = ST_LEN;
                    end
                end
                ST_LEN: begin
                    shift_d = next_word;
                    csum_d  = next_csum;
                    cnt_d   = cnt_q + 2'd1;
                    if (cnt_q == 2'd1) begin
                        left_d  = next_word[31:16];
                        cnt_d   = '0;
                        state_d = (next_word[31:16] == 16'd0) ? ST_CSUM : ST_DATA;
                    end
                end
                ST_DATA: begin
                    shift_d = next_word;
                    csum_d  = next_csum;
                    cnt_d   = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        if (tgt_ok) begin
                            wen_d   = NUM_TARGETS'(1) << tgt_q[2:0];
                            waddr_d = wptr_q;
                            wdata_d = next_word;
                        end
                        wptr_d = wptr_q + ADDR_WIDTH'(1);
                        left_d = left_q - 16'd1;
                        if (left_q == 16'd1) begin
                            state_d = ST_CSUM;
                        end
                    end
                end
                ST_CSUM: begin
                    state_d = ST_IDLE;
                    err_d   = !tgt_ok || (bus.rx_data != csum_q);
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            tgt_q     <= '0;
            shift_q   <= '0;
            wptr_q    <= '0;
            left_q    <= '0;
            csum_q    <= '0;
            timer_q   <= '0;
            wen_q     <= '0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            rst_out_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tgt_q     <= tgt_d;
            shift_q   <= shift_d;
            wptr_q    <= wptr_d;
            left_q    <= left_d;
            csum_q    <= csum_d;
            timer_q   <= timer_d;
            wen_q     <= wen_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            rst_out_q <= rst_out_d;
        end
    end

    assign bus.wen   = wen_q;
    assign bus.waddr = waddr_q;
    assign bus.wdata = wdata_q;
    assign busy_o    = busy;
    assign err_o     = err_q;
    assign rst_out_o = rst_out_q | rst;

`ifdef BOOT_LOADER_ACK_EN
    localparam logic [7:0] ACK_GOOD    = 8'h06;
    localparam logic [7:0] ACK_BADSUM  = 8'h15;
    localparam logic [7:0] ACK_BADTGT  = 8'h16;
    localparam logic [7:0] ACK_TIMEOUT = 8'h17;

    logic       tx_req_q, tx_req_d;
    logic [7:0] tx_data_q, tx_data_d;

    // A fresh status always overwrites one still waiting for tx_ready.
    always_comb begin
        tx_req_d  = tx_req_q;
        tx_data_d = tx_data_q;
        if (timed_out) begin
            tx_req_d  = 1'b1;
            tx_data_d = ACK_TIMEOUT;
        end else if (bus.rx_tick && state_q == ST_CSUM) begin
            tx_req_d = 1'b1;
            if (!tgt_ok) begin
                tx_data_d = ACK_BADTGT;
            end else if (bus.rx_data != csum_q) begin
                tx_data_d = ACK_BADSUM;
            end else begin
                tx_data_d = ACK_GOOD;
            end
        end else if (tx_req_q && bus.tx_ready) begin
            tx_req_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_req_q  <= 1'b0;
            tx_data_q <= '0;
        end else begin
            tx_req_q  <= tx_req_d;
            tx_data_q <= tx_data_d;
        end
    end

    assign bus.tx_req  = tx_req_q;
    assign bus.tx_data = tx_data_q;
`endif

endmodule

// File: tb/tb_uart_boot_loader.sv
// Randomized self-checking bench for uart_boot_loader; frames are built and scored by a queue-based model.
// Defining BOOT_LOADER_ACK_EN also exercises the status-byte handshake.
module tb_uart_boot_loader;
    localparam int AW = 14;
    localparam int NT = 2;
    localparam int TO = 40;

    typedef struct packed {
        logic [NT-1:0] wen;
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    logic prog_en;
    logic rst_out;
    logic busy;
    logic err;

    uart_boot_loader_if #(.ADDR_WIDTH(AW), .NUM_TARGETS(NT)) bus ();

    uart_boot_loader #(
        .ADDR_WIDTH    (AW),
        .NUM_TARGETS   (NT),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .prog_en_i(prog_en),
        .bus      (bus),
        .rst_out_o(rst_out),
        .busy_o   (busy),
        .err_o    (err)
    );

    always #5 clk = ~clk;

    int          compared   = 0;
    int          mismatched = 0;
    logic [7:0]  frame[$];
    logic [31:0] wordsIn[$];
    wr_t         expQ[$];
    wr_t         obsQ[$];
    logic        expErr;

    always @(negedge clk) begin
        if (bus.wen != '0) begin
            obsQ.push_back('{wen: bus.wen, addr: bus.waddr, data: bus.wdata});
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clearModel();
        frame.delete();
        wordsIn.delete();
        expQ.delete();
        obsQ.delete();
    endtask

    // Reference: frame bytes, checksum and expected writes straight from the packet rules.
    task automatic buildFrame(input logic [7:0] tgt, input logic [31:0] addr, input bit corrupt);
        logic [7:0]    cs;
        logic [15:0]   len;
        logic [31:0]   w;
        logic [31:0]   a;
        logic [NT-1:0] oh;
        len = 16'(wordsIn.size());
        frame.push_back(8'hA5);
        frame.push_back(tgt);
        cs = tgt;
        for (int i = 0; i < 4; i++) begin
            frame.push_back(addr[8*i +: 8]);
            cs ^= addr[8*i +: 8];
        end
        for (int i = 0; i < 2; i++) begin
            frame.push_back(len[8*i +: 8]);
            cs ^= len[8*i +: 8];
        end
        for (int k = 0; k < wordsIn.size(); k++) begin
            w = wordsIn[k];
            for (int i = 0; i < 4; i++) begin
                frame.push_back(w[8*i +: 8]);
                cs ^= w[8*i +: 8];
            end
            if (int'(tgt) < NT) begin
                oh = '0;
                oh[tgt] = 1'b1;
                a = (addr + 32'(k)) % (32'd1 << AW);
                expQ.push_back('{wen: oh, addr: a[AW-1:0], data: w});
            end
        end
        frame.push_back(corrupt ? (cs ^ 8'h01) : cs);
        expErr = (int'(tgt) >= NT) || corrupt;
    endtask

    task automatic applyStimulus(input int gapMax, input int dropAt, input int stopAt);
        int n;
        n = (stopAt < 0) ? frame.size() : stopAt;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.rx_data = frame[i];
            bus.rx_tick = 1'b1;
            if (i == dropAt) prog_en = 1'b0;
            repeat ($urandom_range(0, gapMax)) begin
                @(negedge clk);
                bus.rx_tick = 1'b0;
                bus.rx_data = 8'($urandom);
            end
        end
        @(negedge clk);
        bus.rx_tick = 1'b0;
    endtask

    task automatic checkFrame(input string name);
        repeat (3) @(negedge clk);
        checkOutput({name, "_wcount"}, 64'(obsQ.size()), 64'(expQ.size()));
        for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
            checkOutput($sformatf("%s_wen%0d", name, i), 64'(obsQ[i].wen), 64'(expQ[i].wen));
            checkOutput($sformatf("%s_waddr%0d", name, i), 64'(obsQ[i].addr), 64'(expQ[i].addr));
            checkOutput($sformatf("%s_wdata%0d", name, i), 64'(obsQ[i].data), 64'(expQ[i].data));
        end
        checkOutput({name, "_err"}, 64'(err), 64'(expErr));
        checkOutput({name, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [7:0]  tgt;
        logic [7:0]  nb;
        bit          bad;
        rst         = 1'b1;
        prog_en     = 1'b0;
        bus.rx_data = 8'h00;
        bus.rx_tick = 1'b0;
        expErr      = 1'b0;
`ifdef BOOT_LOADER_ACK_EN
        bus.tx_ready = 1'b1;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_err", 64'(err), 64'd0);
        checkOutput("reset_wen", 64'(bus.wen), 64'd0);
        checkOutput("reset_waddr", 64'(bus.waddr), 64'd0);
        checkOutput("reset_wdata", 64'(bus.wdata), 64'd0);
        checkOutput("reset_rstout_first", 64'(rst_out), 64'd1);
        @(negedge clk);
        checkOutput("reset_rstout_idle", 64'(rst_out), 64'd0);

        $display("[TB] good frame");
        prog_en = 1'b1;
        clearModel();
        wordsIn.push_back(32'hDEADBEEF);
        wordsIn.push_back(32'h12345678);
        buildFrame(8'h00, 32'h10, 1'b0);
        applyStimulus(1, -1, -1);
        checkFrame("good");
        checkOutput("good_rstout_held", 64'(rst_out), 64'd1);
        prog_en = 1'b0;
        checkOutput("good_rstout_lag", 64'(rst_out), 64'd1);
        @(negedge clk);
        checkOutput("good_rstout_release", 64'(rst_out), 64'd0);

        $display("[TB] bad checksum");
        prog_en = 1'b1;
        clearModel();
        wordsIn.push_back(32'hDEADBEEF);
        wordsIn.push_back(32'h12345678);
        buildFrame(8'h00, 32'h10, 1'b1);
        applyStimulus(1, -1, -1);
        checkFrame("badsum");
        prog_en = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("badsum_rstout", 64'(rst_out), 64'd1);

        $display("[TB] invalid target");
        prog_en = 1'b1;
        clearModel();
        wordsIn.push_back($urandom);
        buildFrame(8'h05, $urandom, 1'b0);
        applyStimulus(2, -1, -1);
        checkFrame("badtgt");

        $display("[TB] address wrap");
        clearModel();
        wordsIn.push_back($urandom);
        wordsIn.push_back($urandom);
        buildFrame(8'h01, 32'h0000_3FFF, 1'b0);
        applyStimulus(1, -1, -1);
        checkFrame("wrap");

        $display("[TB] zero length");
        clearModel();
        buildFrame(8'h00, $urandom, 1'b0);
        applyStimulus(1, -1, -1);
        checkFrame("len0");

        $display("[TB] frame ignored while prog_en low");
        prog_en = 1'b0;
        clearModel();
        wordsIn.push_back($urandom);
        buildFrame(8'h00, 32'h20, 1'b1);
        expQ.delete();
        expErr = 1'b0;
        applyStimulus(0, -1, -1);
        checkFrame("noprog");

        $display("[TB] prog_en dropped mid-frame");
        prog_en = 1'b1;
        clearModel();
        wordsIn.push_back($urandom);
        wordsIn.push_back($urandom);
        buildFrame(8'h01, $urandom, 1'b0);
        applyStimulus(1, 3, -1);
        checkFrame("dropmid");
        checkOutput("dropmid_rstout", 64'(rst_out), 64'd0);

        $display("[TB] timeout");
        prog_en = 1'b1;
        clearModel();
        wordsIn.push_back($urandom);
        buildFrame(8'h00, 32'h40, 1'b0);
        applyStimulus(0, -1, 11);
        repeat (TO - 3) @(negedge clk);
        checkOutput("timeout_still_busy", 64'(busy), 64'd1);
        repeat (4) @(negedge clk);
        checkOutput("timeout_busy", 64'(busy), 64'd0);
        checkOutput("timeout_err", 64'(err), 64'd1);
        checkOutput("timeout_wcount", 64'(obsQ.size()), 64'd0);

        $display("[TB] reset mid-data");
        clearModel();
        wordsIn.push_back($urandom);
        buildFrame(8'h00, 32'h50, 1'b0);
        applyStimulus(0, -1, 11);
        @(negedge clk);
        bus.rx_data = frame[11];
        bus.rx_tick = 1'b1;
        rst         = 1'b1;
        @(negedge clk);
        bus.rx_tick = 1'b0;
        rst         = 1'b0;
        checkOutput("rstmid_wen", 64'(bus.wen), 64'd0);
        checkOutput("rstmid_busy", 64'(busy), 64'd0);
        checkOutput("rstmid_err", 64'(err), 64'd0);
        repeat (3) @(negedge clk);
        checkOutput("rstmid_wcount", 64'(obsQ.size()), 64'd0);

        $display("[TB] back-to-back with noise");
        clearModel();
        frame.push_back(8'h00);
        frame.push_back(8'hFF);
        wordsIn.push_back($urandom);
        wordsIn.push_back($urandom);
        wordsIn.push_back($urandom);
`ifdef BOOT_LOADER_ACK_EN
        bus.tx_ready = 1'b0;
`endif
        buildFrame(8'h01, $urandom, 1'b0);
        applyStimulus(0, -1, -1);
        checkFrame("b2b");
`ifdef BOOT_LOADER_ACK_EN
        checkOutput("ack_req", 64'(bus.tx_req), 64'd1);
        checkOutput("ack_data", 64'(bus.tx_data), 64'h06);
        repeat (5) @(negedge clk);
        checkOutput("ack_req_held", 64'(bus.tx_req), 64'd1);
        checkOutput("ack_data_held", 64'(bus.tx_data), 64'h06);
        bus.tx_ready = 1'b1;
        @(negedge clk);
        checkOutput("ack_req_drop", 64'(bus.tx_req), 64'd0);
`endif

        $display("[TB] random frames");
        for (int f = 0; f < 12; f++) begin
            clearModel();
            repeat ($urandom_range(0, 2)) begin
                nb = 8'($urandom);
                frame.push_back((nb == 8'hA5) ? 8'h00 : nb);
            end
            tgt = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(2, 255)) : 8'($urandom_range(0, 1));
            bad = ($urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 3)) wordsIn.push_back($urandom);
            buildFrame(tgt, $urandom, bad);
            applyStimulus($urandom_range(0, 2), -1, -1);
            checkFrame($sformatf("rand%0d", f));
            checkOutput($sformatf("rand%0d_rstout", f), 64'(rst_out), 64'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
